booth_wallace_mult16: RTL and testbench

- 16x16 signed multiplier producing a 32-bit two's-complement product.
- Datapath: radix-4 Booth encoding into 8 partial products, a Wallace/CSA reduction tree down to Sum/Carry vectors, then a final carry-propagate adder.
- The intermediate partial products and tree vectors are exported as DFT observation ports so each stage can be checked in isolation.
- One output register stage; it sits as a leaf arithmetic block in the datapath.

---
 rtl/booth_wallace_mult16_pkg.sv | 55 +++++
 rtl/booth_wallace_mult16_if.sv | 29 ++
 rtl/booth_wallace_mult16_csa32.sv | 23 ++
 rtl/booth_wallace_mult16.sv | 73 +++++++
 tb/tb_booth_wallace_mult16.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/booth_wallace_mult16_pkg.sv
// Shared constants, Booth digit type and helper functions for the 16x16 Booth/Wallace multiplier.
package mult_pkg;

    localparam int OP_W   = 16;
    localparam int PROD_W = 32;
    localparam int NUM_PP = 8;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } booth_digit_t;

    typedef logic [PROD_W-1:0] pp_array_t [NUM_PP];

    // Radix-4 recoding of the triplet {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_digit_t booth_decode(input logic [2:0] trip);
        booth_digit_t d;
        case (trip)
            3'b000:  d = ZERO;
            3'b001:  d = POS1;
            3'b010:  d = POS1;
            3'b011:  d = POS2;
            3'b100:  d = NEG2;
            3'b101:  d = NEG1;
            3'b110:  d = NEG1;
            3'b111:  d = ZERO;
            default: d = ZERO;
        endcase
        return d;
    endfunction

    // Unshifted partial product digit*A, sign-extended to full width with
    // the negation +1 folded in so no hot-one terms are needed downstream.
    function automatic logic [PROD_W-1:0] booth_pp(input booth_digit_t d,
                                                   input logic [OP_W-1:0] a);
        logic [PROD_W-1:0] a_ext;
        logic [PROD_W-1:0] a_dbl;
        logic [PROD_W-1:0] pp;
        a_ext = {{(PROD_W-OP_W){a[OP_W-1]}}, a};
        a_dbl = {a_ext[PROD_W-2:0], 1'b0};
        case (d)
            ZERO:    pp = {PROD_W{1'b0}};
            POS1:    pp = a_ext;
            POS2:    pp = a_dbl;
            NEG1:    pp = ~a_ext + 32'd1;
            NEG2:    pp = ~a_dbl + 32'd1;
            default: pp = {PROD_W{1'b0}};
        endcase
        return pp;
    endfunction

endpackage

// File: rtl/booth_wallace_mult16_if.sv
// Operand/observation bundle for booth_wallace_mult16.
interface booth_wallace_mult16_if;
    import mult_pkg::*;

    logic [OP_W-1:0]   Multiplicant;
    logic [OP_W-1:0]   Multiplier;
    logic [PROD_W-1:0] result;
    logic [PROD_W-1:0] PP0;
    logic [PROD_W-1:0] PP1;
    logic [PROD_W-1:0] PP2;
    logic [PROD_W-1:0] PP3;
    logic [PROD_W-1:0] PP4;
    logic [PROD_W-1:0] PP5;
    logic [PROD_W-1:0] PP6;
    logic [PROD_W-1:0] PP7;
    logic [PROD_W-1:0] Sum;
    logic [PROD_W-1:0] Carry;

    modport master (
        output Multiplicant, Multiplier,
        input  result, PP0, PP1, PP2, PP3, PP4, PP5, PP6, PP7, Sum, Carry
    );

    modport slave (
        input  Multiplicant, Multiplier,
        output result, PP0, PP1, PP2, PP3, PP4, PP5, PP6, PP7, Sum, Carry
    );

endinterface

// File: rtl/booth_wallace_mult16_csa32.sv
// 32-bit 3:2 carry-save compressor; carry is pre-shifted to its bit weight.
module csa32
    import mult_pkg::*;
(
    input  logic [PROD_W-1:0] a,
    input  logic [PROD_W-1:0] b,
    input  logic [PROD_W-1:0] c,
    output logic [PROD_W-1:0] sum,
    output logic [PROD_W-1:0] carry
);

    logic [PROD_W-2:0] maj_s;

    // Bitwise full-adder: xor for sum, majority for carry (bit 31 carry drops out).
    always_comb begin
        sum   = a ^ b ^ c;
        maj_s = (a[PROD_W-2:0] & b[PROD_W-2:0]) |
                (a[PROD_W-2:0] & c[PROD_W-2:0]) |
                (b[PROD_W-2:0] & c[PROD_W-2:0]);
        carry = {maj_s, 1'b0};
    end

endmodule

// File: rtl/booth_wallace_mult16.sv
// 16x16 signed radix-4 Booth multiplier with CSA tree and one output register stage.
module booth_wallace_mult16
    import mult_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    booth_wallace_mult16_if.slave   bus
);

    logic [OP_W:0]     b_ext_s;
    pp_array_t         pp_s;
    pp_array_t         pp_r;
    logic [PROD_W-1:0] l1_s0_s, l1_c0_s, l1_s1_s, l1_c1_s;
    logic [PROD_W-1:0] l2_s0_s, l2_c0_s, l2_s1_s, l2_c1_s;
    logic [PROD_W-1:0] l3_s_s,  l3_c_s;
    logic [PROD_W-1:0] tree_sum_s, tree_carry_s;
    logic [PROD_W-1:0] result_s;
    logic [PROD_W-1:0] result_r, sum_r, carry_r;

    assign b_ext_s = {bus.Multiplier, 1'b0};

    // Booth recoding and partial product generation, one slice per digit.
    for (genvar gi = 0; gi < NUM_PP; gi++) begin : g_pp
        booth_digit_t digit_s;
        assign digit_s   = booth_decode(b_ext_s[2*gi +: 3]);
        assign pp_s[gi]  = booth_pp(digit_s, bus.Multiplicant) << (2*gi);
    end

    // Level 1: 8 -> 6
    csa32 u_l1a (.a(pp_s[0]), .b(pp_s[1]), .c(pp_s[2]), .sum(l1_s0_s), .carry(l1_c0_s));
    csa32 u_l1b (.a(pp_s[3]), .b(pp_s[4]), .c(pp_s[5]), .sum(l1_s1_s), .carry(l1_c1_s));
    // Level 2: 6 -> 4
    csa32 u_l2a (.a(l1_s0_s), .b(l1_c0_s), .c(l1_s1_s), .sum(l2_s0_s), .carry(l2_c0_s));
    csa32 u_l2b (.a(l1_c1_s), .b(pp_s[6]), .c(pp_s[7]), .sum(l2_s1_s), .carry(l2_c1_s));
    // Level 3: 4 -> 3
    csa32 u_l3  (.a(l2_s0_s), .b(l2_c0_s), .c(l2_s1_s), .sum(l3_s_s), .carry(l3_c_s));
    // Level 4: 3 -> 2
    csa32 u_l4  (.a(l3_s_s), .b(l3_c_s), .c(l2_c1_s), .sum(tree_sum_s), .carry(tree_carry_s));

    assign result_s = tree_sum_s + tree_carry_s;

    // Single output stage: all observation vectors and the product update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r <= 32'd0;
            sum_r    <= 32'd0;
            carry_r  <= 32'd0;
            for (int i = 0; i < NUM_PP; i++) begin
                pp_r[i] <= 32'd0;
            end
        end else begin
            result_r <= result_s;
            sum_r    <= tree_sum_s;
            carry_r  <= tree_carry_s;
            for (int i = 0; i < NUM_PP; i++) begin
                pp_r[i] <= pp_s[i];
            end
        end
    end

    assign bus.result = result_r;
    assign bus.Sum    = sum_r;
    assign bus.Carry  = carry_r;
    assign bus.PP0    = pp_r[0];
    assign bus.PP1    = pp_r[1];
    assign bus.PP2    = pp_r[2];
    assign bus.PP3    = pp_r[3];
    assign bus.PP4    = pp_r[4];
    assign bus.PP5    = pp_r[5];
    assign bus.PP6    = pp_r[6];
    assign bus.PP7    = pp_r[7];

endmodule

// File: tb/tb_booth_wallace_mult16.sv
// Self-checking bench: arithmetic reference model plus directed literal checks.
module tb_booth_wallace_mult16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    booth_wallace_mult16_if bus ();

    booth_wallace_mult16 dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [31:0] dut_pp [8];
    assign dut_pp[0] = bus.PP0;
    assign dut_pp[1] = bus.PP1;
    assign dut_pp[2] = bus.PP2;
    assign dut_pp[3] = bus.PP3;
    assign dut_pp[4] = bus.PP4;
    assign dut_pp[5] = bus.PP5;
    assign dut_pp[6] = bus.PP6;
    assign dut_pp[7] = bus.PP7;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference: signed product in 64-bit arithmetic, truncated.
    function automatic logic [31:0] model_prod(input logic [15:0] a, input logic [15:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[31:0];
    endfunction

    // Reference: Booth digit value is b[2i-1] + b[2i] - 2*b[2i+1]; PP = digit*A*4^i.
    function automatic logic [31:0] model_pp(input logic [15:0] a, input logic [15:0] b, input int i);
        logic [16:0] bx;
        int d;
        longint v;
        bx = {b, 1'b0};
        d = int'(bx[2*i]) + int'(bx[2*i+1]) - 2 * int'(bx[2*i+2]);
        v = longint'(d) * longint'($signed(a)) * (longint'(1) << (2*i));
        return v[31:0];
    endfunction

    logic        model_valid = 1'b0;
    logic        exp_zero;
    logic [31:0] exp_result;
    logic [31:0] exp_pp [8];

    // Model state: what the registered outputs must hold after each edge.
    always @(posedge clk) begin
        model_valid <= 1'b1;
        if (rst) begin
            exp_zero   <= 1'b1;
            exp_result <= 32'd0;
            for (int i = 0; i < 8; i++) exp_pp[i] <= 32'd0;
        end else begin
            exp_zero   <= (bus.Multiplicant == 16'd0) || (bus.Multiplier == 16'd0);
            exp_result <= model_prod(bus.Multiplicant, bus.Multiplier);
            for (int i = 0; i < 8; i++) exp_pp[i] <= model_pp(bus.Multiplicant, bus.Multiplier, i);
        end
    end

    // Compare process on the falling edge, away from the sampling edge.
    always @(negedge clk) begin
        if (model_valid) begin
            logic [31:0] pp_sum;
            pp_sum = 32'd0;
            chk("result", bus.result, exp_result);
            chk("sum_plus_carry", bus.Sum + bus.Carry, exp_result);
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("pp%0d", i), dut_pp[i], exp_pp[i]);
                pp_sum = pp_sum + dut_pp[i];
            end
            chk("pp_total", pp_sum, exp_result);
            if (exp_zero) begin
                chk("sum_zero", bus.Sum, 32'd0);
                chk("carry_zero", bus.Carry, 32'd0);
            end
        end
    end

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic r);
        bus.Multiplicant = a;
        bus.Multiplier   = b;
        rst              = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] corners [5];

    initial begin
        corners[0] = 16'h8000;
        corners[1] = 16'h7FFF;
        corners[2] = 16'h0000;
        corners[3] = 16'h0001;
        corners[4] = 16'hFFFF;

        // Reset held two cycles with live operands.
        drive(16'h1234, 16'h5678, 1'b1);
        step();
        step();
        chk("rst_result", bus.result, 32'd0);
        chk("rst_pp0", bus.PP0, 32'd0);
        chk("rst_sum", bus.Sum, 32'd0);
        chk("rst_carry", bus.Carry, 32'd0);
        drive(16'h1234, 16'h5678, 1'b0);
        step();
        chk("rel_result", bus.result, 32'h06260060);

        // Booth partial product pinning: 7 * 3.
        drive(16'd7, 16'd3, 1'b0);
        step();
        chk("b_pp0", bus.PP0, 32'hFFFFFFF9);
        chk("b_pp1", bus.PP1, 32'h0000001C);
        chk("b_pp2", bus.PP2, 32'h00000000);
        chk("b_pp7", bus.PP7, 32'h00000000);
        chk("b_result", bus.result, 32'h00000015);
        chk("b_sc", bus.Sum + bus.Carry, 32'h00000015);

        // Sign corners, back to back.
        drive(16'hFFFF, 16'hFFFF, 1'b0);
        step();
        chk("m1xm1", bus.result, 32'h00000001);
        drive(16'h8000, 16'h8000, 1'b0);
        step();
        chk("minxmin", bus.result, 32'h40000000);
        drive(16'h8000, 16'h7FFF, 1'b0);
        step();
        chk("minxmax", bus.result, 32'hC0008000);

        // Pipelined stream.
        drive(16'd3, 16'd5, 1'b0);
        step();
        chk("pipe0", bus.result, 32'd15);
        drive(16'hFFFE, 16'd9, 1'b0);
        step();
        chk("pipe1", bus.result, 32'hFFFFFFEE);
        drive(16'd0, 16'h7FFF, 1'b0);
        step();
        chk("pipe2", bus.result, 32'd0);
        chk("pipe2_sum", bus.Sum, 32'd0);
        chk("pipe2_carry", bus.Carry, 32'd0);

        // Reset in the middle of a stream, then immediate recovery.
        drive(16'd100, 16'd200, 1'b0);
        step();
        chk("mid_pre", bus.result, 32'd20000);
        drive(16'd300, 16'd400, 1'b1);
        step();
        chk("mid_rst", bus.result, 32'd0);
        chk("mid_rst_pp1", bus.PP1, 32'd0);
        drive(16'd11, 16'hFFF3, 1'b0);
        step();
        chk("mid_post", bus.result, 32'hFFFFFF71);

        // Corner cross product, checked by the model process.
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                drive(corners[i], corners[j], 1'b0);
                step();
            end
        end

        // Random pairs.
        for (int k = 0; k < 2000; k++) begin
            drive(16'($urandom), 16'($urandom), 1'b0);
            step();
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
